// File: rtl/fetch.sv
// fetch: RV32I instruction-fetch stage. Issues in-order imem requests, buffers
// responses in a small FIFO, applies static JAL/backward-branch prediction and absorbs flushes.
module fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        req,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [31:0] flush_pc_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        branch_predicted_taken_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_pc;
  logic [31:0]   r_pendAddr;
  logic          r_pending;
  logic          r_stale;
  logic [CW-1:0] r_fifoCount;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [AW-1:0] r_fifoRd;
  logic [AW-1:0] r_fifoWr;
  logic [AW-1:0] r_pqRd;
  logic [AW-1:0] r_pqWr;
  logic [31:0]   r_fifoInstr [FIFO_DEPTH];
  logic [31:0]   r_fifoPc    [FIFO_DEPTH];
  logic          r_fifoPred  [FIFO_DEPTH];
  logic [31:0]   r_pcQueue   [FIFO_DEPTH];

  logic          w_space;
  logic          w_reqRaw;
  logic [31:0]   w_addr;
  logic          w_grant;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_rspPc;
  logic [31:0]   w_jImm;
  logic [31:0]   w_bImm;
  logic          w_isJal;
  logic          w_isBackBr;
  logic [31:0]   w_target;
  logic          w_predTaken;
  logic          w_redirect;
  logic [31:0]   w_redirectPc;
  logic [CW-1:0] w_outNext;
  logic [CW-1:0] w_discardNext;
  logic [CW-1:0] w_countNext;

  // A pending ungranted request keeps its address even if fetch PC is redirected meanwhile.
  assign w_space  = ({1'b0, r_fifoCount} + {1'b0, r_outstanding}) < DEPTH_W;
  assign w_reqRaw = r_pending | w_space;
  assign w_addr   = r_pending ? r_pendAddr : r_pc;
  assign w_grant  = w_reqRaw & imem_gnt_in;

  assign imem_req_out  = reset & w_reqRaw;
  assign imem_addr_out = w_addr;

  assign w_drop  = imem_rvalid_in & (r_discard != '0);
  assign w_push  = imem_rvalid_in & ~w_drop & ~flush_in;
  assign w_pop   = (r_fifoCount != '0) & ~stall_in;
  assign w_rspPc = r_pcQueue[r_pqRd];

  assign w_jImm      = {{12{imem_rdata_in[31]}}, imem_rdata_in[19:12], imem_rdata_in[20],
                        imem_rdata_in[30:21], 1'b0};
  assign w_bImm      = {{20{imem_rdata_in[31]}}, imem_rdata_in[7], imem_rdata_in[30:25],
                        imem_rdata_in[11:8], 1'b0};
  assign w_isJal     = (imem_rdata_in[6:0] == 7'b1101111);
  assign w_isBackBr  = (imem_rdata_in[6:0] == 7'b1100011) & imem_rdata_in[31];
  assign w_target    = w_rspPc + (w_isJal ? w_jImm : w_bImm);
  assign w_predTaken = w_push & (w_isJal | w_isBackBr);

  assign w_redirect   = flush_in | w_predTaken;
  assign w_redirectPc = flush_in ? flush_pc_in : w_target;

  // On redirect every response still in flight after this edge is wrong-path, including this cycle's grant.
  always_comb begin
    w_outNext     = r_outstanding;
    w_discardNext = r_discard;
    w_countNext   = r_fifoCount;
    if (w_grant && !imem_rvalid_in) begin
      w_outNext = r_outstanding + 1'b1;
    end else if (!w_grant && imem_rvalid_in) begin
      w_outNext = r_outstanding - 1'b1;
    end
    if (w_drop) begin
      w_discardNext = w_discardNext - 1'b1;
    end
    if (w_grant && r_stale) begin
      w_discardNext = w_discardNext + 1'b1;
    end
    if (w_redirect) begin
      w_discardNext = w_outNext;
    end
    if (w_push && !w_pop) begin
      w_countNext = r_fifoCount + 1'b1;
    end else if (!w_push && w_pop) begin
      w_countNext = r_fifoCount - 1'b1;
    end
  end

  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_pendAddr    <= RESET_PC;
      r_pending     <= 1'b0;
      r_stale       <= 1'b0;
      r_fifoCount   <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_fifoRd      <= '0;
      r_fifoWr      <= '0;
      r_pqRd        <= '0;
      r_pqWr        <= '0;
    end else begin
      r_pending     <= w_reqRaw & ~imem_gnt_in;
      r_pendAddr    <= w_addr;
      r_stale       <= w_reqRaw & ~imem_gnt_in & (r_stale | w_redirect);
      r_outstanding <= w_outNext;
      r_discard     <= w_discardNext;
      if (w_redirect) begin
        r_pc <= w_redirectPc;
      end else if (w_grant && !r_stale) begin
        r_pc <= w_addr + 32'd4;
      end
      if (w_grant) begin
        r_pqWr <= r_pqWr + 1'b1;
      end
      if (imem_rvalid_in) begin
        r_pqRd <= r_pqRd + 1'b1;
      end
      if (flush_in) begin
        r_fifoCount <= '0;
        r_fifoRd    <= '0;
        r_fifoWr    <= '0;
      end else begin
        r_fifoCount <= w_countNext;
        if (w_push) begin
          r_fifoWr <= r_fifoWr + 1'b1;
        end
        if (w_pop) begin
          r_fifoRd <= r_fifoRd + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge req) begin
    if (w_grant) begin
      r_pcQueue[r_pqWr] <= w_addr;
    end
    if (w_push) begin
      r_fifoInstr[r_fifoWr] <= imem_rdata_in;
      r_fifoPc[r_fifoWr]    <= w_rspPc;
      r_fifoPred[r_fifoWr]  <= w_predTaken;
    end
  end

  assign valid_out                  = (r_fifoCount != '0);
  assign instr_out                  = valid_out ? r_fifoInstr[r_fifoRd] : NOP;
  assign pc_out                     = valid_out ? r_fifoPc[r_fifoRd] : 32'h0000_0000;
  assign branch_predicted_taken_out = valid_out ? r_fifoPred[r_fifoRd] : 1'b0;
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed bench for the fetch stage with a small in-order
// instruction-memory model of configurable response latency.
module tb_fetch;
  logic        req = 1'b0;
  logic        reset = 1'b1;
  logic        stall_in = 1'b0;
  logic        flush_in = 1'b0;
  logic [31:0] flush_pc_in = 32'h0;
  logic        imem_gnt_in = 1'b1;
  logic        imem_rvalid_in = 1'b0;
  logic [31:0] imem_rdata_in = 32'h0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        branch_predicted_taken_out;

  fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .req                        (req),
    .reset                      (reset),
    .stall_in                   (stall_in),
    .flush_in                   (flush_in),
    .flush_pc_in                (flush_pc_in),
    .imem_req_out               (imem_req_out),
    .imem_addr_out              (imem_addr_out),
    .imem_gnt_in                (imem_gnt_in),
    .imem_rvalid_in             (imem_rvalid_in),
    .imem_rdata_in              (imem_rdata_in),
    .valid_out                  (valid_out),
    .instr_out                  (instr_out),
    .pc_out                     (pc_out),
    .branch_predicted_taken_out (branch_predicted_taken_out)
  );

  always #5 req = ~req;

  typedef struct {
    logic        stall;
    logic        expValid;
    logic [31:0] expPc;
    logic [31:0] expInstr;
    logic        expPred;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t memQ[$];
  int   memLatency = 1;
  int   cycleNo = 0;
  int   nVectors = 0;
  int   nMiscompares = 0;

  // Small program image: backward beq at 0x20, jal +16 at 0x40, forward beq at 0x60.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0020: return 32'hFE00_0EE3;
      32'h0000_0040: return 32'h0100_006F;
      32'h0000_0060: return 32'h0000_0863;
      default:       return 32'h0000_0013;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One clock: sample grant before the edge, then update the memory model after it.
  task automatic tick();
    logic        granted;
    logic [31:0] grantAddr;
    @(negedge req);
    granted   = imem_req_out && imem_gnt_in;
    grantAddr = imem_addr_out;
    @(posedge req);
    #1;
    cycleNo++;
    if (!reset) begin
      memQ.delete();
      imem_rvalid_in = 1'b0;
    end else begin
      if (granted) begin
        memQ.push_back('{grantAddr, cycleNo + memLatency - 1});
      end
      if (memQ.size() > 0 && memQ[0].due <= cycleNo) begin
        imem_rvalid_in = 1'b1;
        imem_rdata_in  = memWord(memQ[0].addr);
        void'(memQ.pop_front());
      end else begin
        imem_rvalid_in = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic flush, input logic [31:0] flushPc);
    stall_in    = stall;
    flush_in    = flush;
    flush_pc_in = flushPc;
    tick();
    stall_in = 1'b0;
    flush_in = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req"},   {31'b0, imem_req_out}, 32'd0);
    checkOutput({tag, "_addr"},  imem_addr_out, 32'h0000_0000);
    checkOutput({tag, "_valid"}, {31'b0, valid_out}, 32'd0);
    checkOutput({tag, "_instr"}, instr_out, 32'h0000_0013);
    checkOutput({tag, "_pc"},    pc_out, 32'h0000_0000);
    checkOutput({tag, "_pred"},  {31'b0, branch_predicted_taken_out}, 32'd0);
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc, input logic [31:0] instr, input logic pred);
    checkOutput({tag, "_valid"}, {31'b0, valid_out}, 32'd1);
    checkOutput({tag, "_pc"},    pc_out, pc);
    checkOutput({tag, "_instr"}, instr_out, instr);
    checkOutput({tag, "_pred"},  {31'b0, branch_predicted_taken_out}, {31'b0, pred});
  endtask

  task automatic waitValid(input string tag, input int maxCycles);
    int n = 0;
    while (valid_out !== 1'b1 && n < maxCycles) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      n++;
    end
    checkOutput({tag, "_arrive"}, {31'b0, valid_out}, 32'd1);
  endtask

  task automatic applyReset(input logic gnt);
    reset          = 1'b0;
    stall_in       = 1'b0;
    flush_in       = 1'b0;
    imem_gnt_in    = gnt;
    imem_rvalid_in = 1'b0;
    memQ.delete();
    #1;
    checkResetState("reset");
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    vec_t streamVecs[17];
    streamVecs = '{
      '{1'b0, 1'b0, 32'h00, 32'h0000_0013, 1'b0},
      '{1'b0, 1'b1, 32'h00, 32'h0000_0013, 1'b0},
      '{1'b0, 1'b1, 32'h04, 32'h0000_0013, 1'b0},
      '{1'b0, 1'b1, 32'h08, 32'h0000_0013, 1'b0},
      '{1'b0, 1'b1, 32'h0C, 32'h0000_0013, 1'b0},
      '{1'b0, 1'b1, 32'h10, 32'h0000_0013, 1'b0},
      '{1'b0, 1'b1, 32'h14, 32'h0000_0013, 1'b0},
      '{1'b0, 1'b1, 32'h18, 32'h0000_0013, 1'b0},
      '{1'b0, 1'b1, 32'h1C, 32'h0000_0013, 1'b0},
      '{1'b0, 1'b1, 32'h20, 32'hFE00_0EE3, 1'b1},
      '{1'b0, 1'b0, 32'h00, 32'h0000_0013, 1'b0},
      '{1'b0, 1'b1, 32'h1C, 32'h0000_0013, 1'b0},
      '{1'b0, 1'b1, 32'h20, 32'hFE00_0EE3, 1'b1},
      '{1'b0, 1'b0, 32'h00, 32'h0000_0013, 1'b0},
      '{1'b0, 1'b1, 32'h1C, 32'h0000_0013, 1'b0},
      '{1'b0, 1'b1, 32'h20, 32'hFE00_0EE3, 1'b1},
      '{1'b0, 1'b0, 32'h00, 32'h0000_0013, 1'b0}
    };
    #2;

    // Streaming from reset into the backward-branch loop at 0x1C/0x20.
    memLatency = 1;
    applyReset(1'b1);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(streamVecs[i].stall, 1'b0, 32'h0);
      checkOutput($sformatf("stream%0d_valid", i + 1), {31'b0, valid_out}, {31'b0, streamVecs[i].expValid});
      if (streamVecs[i].expValid) begin
        checkOutput($sformatf("stream%0d_pc", i + 1), pc_out, streamVecs[i].expPc);
        checkOutput($sformatf("stream%0d_instr", i + 1), instr_out, streamVecs[i].expInstr);
        checkOutput($sformatf("stream%0d_pred", i + 1), {31'b0, branch_predicted_taken_out},
                    {31'b0, streamVecs[i].expPred});
      end
    end

    // Decode stall for 8 cycles: head holds, requests stop, then stream resumes gap-free.
    applyReset(1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkHead("prestall", 32'h04, 32'h13, 1'b0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput($sformatf("stall%0d_pc", k), pc_out, 32'h04);
      if (k == 0) checkOutput("stall_req_early", {31'b0, imem_req_out}, 32'd1);
      if (k == 7) checkOutput("stall_req_full", {31'b0, imem_req_out}, 32'd0);
    end
    for (int j = 0; j < 6; j++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("resume%0d_valid", j), {31'b0, valid_out}, 32'd1);
      checkOutput($sformatf("resume%0d_pc", j), pc_out, 32'h08 + 32'(4 * j));
    end

    // Flush to 0x100 with two responses outstanding on a 3-cycle memory.
    memLatency = 3;
    applyReset(1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h100);
    checkOutput("flush_valid_after", {31'b0, valid_out}, 32'd0);
    waitValid("flush100", 20);
    checkHead("flush100", 32'h100, 32'h13, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    waitValid("flush104", 20);
    checkOutput("flush104_pc", pc_out, 32'h104);

    // Flush arrives in the same cycle the backward branch at 0x20 would be pushed.
    memLatency = 1;
    applyReset(1'b1);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkHead("prebranch", 32'h1C, 32'h13, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h300);
    checkOutput("flushbr_valid_after", {31'b0, valid_out}, 32'd0);
    waitValid("flushbr300", 20);
    checkHead("flushbr300", 32'h300, 32'h13, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    waitValid("flushbr304", 20);
    checkOutput("flushbr304_pc", pc_out, 32'h304);

    // JAL +16 at 0x40 is predicted taken; forward beq at 0x60 is not.
    applyStimulus(1'b0, 1'b1, 32'h40);
    waitValid("jal", 20);
    checkHead("jal", 32'h40, 32'h0100_006F, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    waitValid("jaltgt", 20);
    checkHead("jaltgt", 32'h50, 32'h13, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h60);
    waitValid("fwdbeq", 20);
    checkHead("fwdbeq", 32'h60, 32'h0000_0863, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    waitValid("fwdnext", 20);
    checkHead("fwdnext", 32'h64, 32'h13, 1'b0);

    // Flush while a request waits for grant: address holds, stale response is dropped.
    applyReset(1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("pend_req", {31'b0, imem_req_out}, 32'd1);
    checkOutput("pend_addr", imem_addr_out, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h80);
    checkOutput("stale_req", {31'b0, imem_req_out}, 32'd1);
    checkOutput("stale_addr", imem_addr_out, 32'h0);
    imem_gnt_in = 1'b1;
    waitValid("stale80", 20);
    checkHead("stale80", 32'h80, 32'h13, 1'b0);

    // Asynchronous reset mid-stream with three responses outstanding.
    memLatency = 3;
    applyReset(1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkHead("midstream", 32'h04, 32'h13, 1'b0);
    reset = 1'b0;
    #1;
    checkResetState("midreset");
    memQ.delete();
    imem_rvalid_in = 1'b0;
    memLatency = 1;
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("restart1_valid", {31'b0, valid_out}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkHead("restart2", 32'h00, 32'h13, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkHead("restart3", 32'h04, 32'h13, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end
endmodule
